// File: rtl/fwd_stall_if.sv
`default_nettype none
// ============================================================================
// Module   : fwd_stall_if
// Purpose  : ID-stage forwarding/interlock bundle between pipeline and controller
// Revision : 1.0
// ============================================================================
interface fwd_stall_if #(
    parameter int DW    = 32,
    parameter int RW    = 5,
    parameter int CNT_W = 16
);
    logic              flush;
    logic [RW-1:0]     id_rs;
    logic [RW-1:0]     id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_wreg;
    logic              id_wmem;
    logic [DW-1:0]     id_ra_org;
    logic [DW-1:0]     id_rb_org;
    logic [RW-1:0]     exe_rn;
    logic [RW-1:0]     mem_rn;
    logic [RW-1:0]     wb_rn;
    logic              exe_wreg;
    logic              mem_wreg;
    logic              wb_wreg;
    logic              exe_m2reg;
    logic              mem_m2reg;
    logic [DW-1:0]     exe_alu;
    logic [DW-1:0]     mem_alu;
    logic [DW-1:0]     mem_mo;
    logic [DW-1:0]     wb_wdi;
    logic [DW-1:0]     id_ra;
    logic [DW-1:0]     id_rb;
    logic [2:0]        fwd_a;
    logic [2:0]        fwd_b;
    logic              stall;
    logic              id_wreg_q;
    logic              id_wmem_q;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  fwd_cnt;

    modport master (
        output flush, id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_wmem,
               id_ra_org, id_rb_org, exe_rn, mem_rn, wb_rn, exe_wreg, mem_wreg,
               wb_wreg, exe_m2reg, mem_m2reg, exe_alu, mem_alu, mem_mo, wb_wdi,
        input  id_ra, id_rb, fwd_a, fwd_b, stall, id_wreg_q, id_wmem_q,
               stall_cnt, fwd_cnt
    );

    modport slave (
        input  flush, id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_wmem,
               id_ra_org, id_rb_org, exe_rn, mem_rn, wb_rn, exe_wreg, mem_wreg,
               wb_wreg, exe_m2reg, mem_m2reg, exe_alu, mem_alu, mem_mo, wb_wdi,
        output id_ra, id_rb, fwd_a, fwd_b, stall, id_wreg_q, id_wmem_q,
               stall_cnt, fwd_cnt
    );
endinterface
`default_nettype wire

// File: rtl/fwd_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fwd_stall_ctrl
// Purpose  : ID operand forwarding, load-use interlock FSM and perf counters
// Revision : 1.0
// ============================================================================
module fwd_stall_ctrl #(
    parameter int DW       = 32,
    parameter int RW       = 5,
    parameter int LD_STALL = 1,
    parameter int CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    fwd_stall_if.slave  bus
);
    localparam logic [2:0] c_SEL_ORG = 3'b000;
    localparam logic [2:0] c_SEL_EXE = 3'b001;
    localparam logic [2:0] c_SEL_MEM = 3'b010;
    localparam logic [2:0] c_SEL_MO  = 3'b011;
    localparam logic [2:0] c_SEL_WB  = 3'b100;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t            r_state_q, r_state_d;
    logic [1:0]        r_cnt_q, r_cnt_d;
    logic [CNT_W-1:0]  r_stall_cnt_q, r_stall_cnt_d;
    logic [CNT_W-1:0]  r_fwd_cnt_q, r_fwd_cnt_d;

    logic w_hit_e_rs, w_hit_e_rt, w_hit_m_rs, w_hit_m_rt, w_hit_w_rs, w_hit_w_rt;
    logic w_haz_e, w_haz_m, w_stall_raw, w_stall;
    logic [2:0]    w_fwd_a, w_fwd_b;
    logic [DW-1:0] w_ra, w_rb;

    function automatic logic f_hit(input logic use_x, input logic wreg,
                                   input logic [RW-1:0] rn, input logic [RW-1:0] x);
        return use_x && wreg && (rn == x) && (x != '0);
    endfunction

    // A load hit in a stage that cannot yet supply data shadows older stages
    function automatic logic [2:0] f_sel(input logic hit_e, input logic hit_m,
                                         input logic hit_w, input logic exe_ld,
                                         input logic mem_ld);
        if (hit_e) return exe_ld ? c_SEL_ORG : c_SEL_EXE;
        if (hit_m) begin
            if (!mem_ld) return c_SEL_MEM;
            return (LD_STALL == 1) ? c_SEL_MO : c_SEL_ORG;
        end
        if (hit_w) return c_SEL_WB;
        return c_SEL_ORG;
    endfunction

    assign w_hit_e_rs = f_hit(bus.id_use_rs, bus.exe_wreg, bus.exe_rn, bus.id_rs);
    assign w_hit_e_rt = f_hit(bus.id_use_rt, bus.exe_wreg, bus.exe_rn, bus.id_rt);
    assign w_hit_m_rs = f_hit(bus.id_use_rs, bus.mem_wreg, bus.mem_rn, bus.id_rs);
    assign w_hit_m_rt = f_hit(bus.id_use_rt, bus.mem_wreg, bus.mem_rn, bus.id_rt);
    assign w_hit_w_rs = f_hit(bus.id_use_rs, bus.wb_wreg,  bus.wb_rn,  bus.id_rs);
    assign w_hit_w_rt = f_hit(bus.id_use_rt, bus.wb_wreg,  bus.wb_rn,  bus.id_rt);

    assign w_fwd_a = f_sel(w_hit_e_rs, w_hit_m_rs, w_hit_w_rs, bus.exe_m2reg, bus.mem_m2reg);
    assign w_fwd_b = f_sel(w_hit_e_rt, w_hit_m_rt, w_hit_w_rt, bus.exe_m2reg, bus.mem_m2reg);

    assign w_haz_e = (w_hit_e_rs | w_hit_e_rt) & bus.exe_m2reg;
    assign w_haz_m = (w_hit_m_rs | w_hit_m_rt) & bus.mem_m2reg & (LD_STALL == 2);

    always_comb begin
        w_ra = bus.id_ra_org;
        w_rb = bus.id_rb_org;
        case (w_fwd_a)
            c_SEL_EXE: w_ra = bus.exe_alu;
            c_SEL_MEM: w_ra = bus.mem_alu;
            c_SEL_MO:  w_ra = bus.mem_mo;
            c_SEL_WB:  w_ra = bus.wb_wdi;
            default:   w_ra = bus.id_ra_org;
        endcase
        case (w_fwd_b)
            c_SEL_EXE: w_rb = bus.exe_alu;
            c_SEL_MEM: w_rb = bus.mem_alu;
            c_SEL_MO:  w_rb = bus.mem_mo;
            c_SEL_WB:  w_rb = bus.wb_wdi;
            default:   w_rb = bus.id_rb_org;
        endcase
    end

    always_comb begin
        r_state_d   = r_state_q;
        r_cnt_d     = r_cnt_q;
        w_stall_raw = 1'b0;
        if (bus.flush) begin
            r_state_d = ST_RUN;
            r_cnt_d   = 2'd0;
        end else begin
            case (r_state_q)
                ST_RUN: begin
                    w_stall_raw = w_haz_e | w_haz_m;
                    // First bubble is this cycle; HOLD supplies the rest
                    if (w_haz_e && (LD_STALL == 2)) begin
                        r_cnt_d   = 2'd1;
                        r_state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    w_stall_raw = 1'b1;
                    r_cnt_d     = (r_cnt_q != 2'd0) ? r_cnt_q - 2'd1 : 2'd0;
                    if (r_cnt_d == 2'd0) r_state_d = ST_RUN;
                end
                default: begin
                    r_state_d = ST_RUN;
                    r_cnt_d   = 2'd0;
                end
            endcase
        end
    end

    assign w_stall = w_stall_raw & ~rst;

    always_comb begin
        r_stall_cnt_d = r_stall_cnt_q;
        r_fwd_cnt_d   = r_fwd_cnt_q;
        if (w_stall && (r_stall_cnt_q != '1))
            r_stall_cnt_d = r_stall_cnt_q + CNT_W'(1);
        if (!w_stall && !bus.flush && ((w_fwd_a != c_SEL_ORG) || (w_fwd_b != c_SEL_ORG))
            && (r_fwd_cnt_q != '1))
            r_fwd_cnt_d = r_fwd_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= ST_RUN;
            r_cnt_q       <= 2'd0;
            r_stall_cnt_q <= '0;
            r_fwd_cnt_q   <= '0;
        end else begin
            r_state_q     <= r_state_d;
            r_cnt_q       <= r_cnt_d;
            r_stall_cnt_q <= r_stall_cnt_d;
            r_fwd_cnt_q   <= r_fwd_cnt_d;
        end
    end

    assign bus.id_ra     = w_ra;
    assign bus.id_rb     = w_rb;
    assign bus.fwd_a     = w_fwd_a;
    assign bus.fwd_b     = w_fwd_b;
    assign bus.stall     = w_stall;
    assign bus.id_wreg_q = bus.id_wreg & ~(w_stall | bus.flush | rst);
    assign bus.id_wmem_q = bus.id_wmem & ~(w_stall | bus.flush | rst);
    assign bus.stall_cnt = r_stall_cnt_q;
    assign bus.fwd_cnt   = r_fwd_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_fwd_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_stall_ctrl
// Purpose  : Directed bench for fwd_stall_ctrl (LD_STALL=1/CNT_W=4 and LD_STALL=2/CNT_W=16)
// Revision : 1.0
// ============================================================================
module tb_fwd_stall_ctrl;
    localparam int DW = 32;
    localparam int RW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          flush, id_use_rs, id_use_rt, id_wreg, id_wmem;
    logic [RW-1:0] id_rs, id_rt, exe_rn, mem_rn, wb_rn;
    logic          exe_wreg, mem_wreg, wb_wreg, exe_m2reg, mem_m2reg;
    logic [DW-1:0] id_ra_org, id_rb_org, exe_alu, mem_alu, mem_mo, wb_wdi;

    fwd_stall_if #(.DW(DW), .RW(RW), .CNT_W(4))  bus1 ();
    fwd_stall_if #(.DW(DW), .RW(RW), .CNT_W(16)) bus2 ();

`define TB_DRIVE(b) \
    assign b.flush = flush; assign b.id_rs = id_rs; assign b.id_rt = id_rt; \
    assign b.id_use_rs = id_use_rs; assign b.id_use_rt = id_use_rt; \
    assign b.id_wreg = id_wreg; assign b.id_wmem = id_wmem; \
    assign b.id_ra_org = id_ra_org; assign b.id_rb_org = id_rb_org; \
    assign b.exe_rn = exe_rn; assign b.mem_rn = mem_rn; assign b.wb_rn = wb_rn; \
    assign b.exe_wreg = exe_wreg; assign b.mem_wreg = mem_wreg; assign b.wb_wreg = wb_wreg; \
    assign b.exe_m2reg = exe_m2reg; assign b.mem_m2reg = mem_m2reg; \
    assign b.exe_alu = exe_alu; assign b.mem_alu = mem_alu; \
    assign b.mem_mo = mem_mo; assign b.wb_wdi = wb_wdi;
    `TB_DRIVE(bus1)
    `TB_DRIVE(bus2)
`undef TB_DRIVE

    fwd_stall_ctrl #(.DW(DW), .RW(RW), .LD_STALL(1), .CNT_W(4)) u1 (
        .clk(clk), .rst(rst), .bus(bus1.slave));
    fwd_stall_ctrl #(.DW(DW), .RW(RW), .LD_STALL(2), .CNT_W(16)) u2 (
        .clk(clk), .rst(rst), .bus(bus2.slave));

    logic [2:0]    o_fa[2], o_fb[2];
    logic [DW-1:0] o_ra[2], o_rb[2];
    logic          o_st[2], o_wq[2], o_mq[2];
    logic [15:0]   o_sc[2], o_fc[2];
    assign o_fa[0] = bus1.fwd_a;     assign o_fa[1] = bus2.fwd_a;
    assign o_fb[0] = bus1.fwd_b;     assign o_fb[1] = bus2.fwd_b;
    assign o_ra[0] = bus1.id_ra;     assign o_ra[1] = bus2.id_ra;
    assign o_rb[0] = bus1.id_rb;     assign o_rb[1] = bus2.id_rb;
    assign o_st[0] = bus1.stall;     assign o_st[1] = bus2.stall;
    assign o_wq[0] = bus1.id_wreg_q; assign o_wq[1] = bus2.id_wreg_q;
    assign o_mq[0] = bus1.id_wmem_q; assign o_mq[1] = bus2.id_wmem_q;
    assign o_sc[0] = {12'd0, bus1.stall_cnt}; assign o_sc[1] = bus2.stall_cnt;
    assign o_fc[0] = {12'd0, bus1.fwd_cnt};   assign o_fc[1] = bus2.fwd_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic started = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_ld[2]  = '{1, 2};
    int          m_max[2] = '{15, 65535};
    int          m_extra[2] = '{0, 0};   // bubbles still owed after the current one
    int          m_sc[2]    = '{0, 0};
    int          m_fc[2]    = '{0, 0};

    function automatic int exp_sel(input int ld, input logic use_x, input logic [RW-1:0] x);
        if (!use_x || x == 0) return 0;
        if (exe_wreg && exe_rn == x) return exe_m2reg ? 0 : 1;
        if (mem_wreg && mem_rn == x) return mem_m2reg ? ((ld == 1) ? 3 : 0) : 2;
        if (wb_wreg && wb_rn == x) return 4;
        return 0;
    endfunction

    function automatic logic dep(input logic [RW-1:0] rn, input logic wreg);
        return wreg && rn != 0 && ((id_use_rs && id_rs == rn) || (id_use_rt && id_rt == rn));
    endfunction

    function automatic logic [DW-1:0] src(input int s, input logic [DW-1:0] org);
        case (s)
            1: return exe_alu;
            2: return mem_alu;
            3: return mem_mo;
            4: return wb_wdi;
            default: return org;
        endcase
    endfunction

    int   e_sa, e_sb;
    logic e_he, e_hm, e_st;
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                e_sa = exp_sel(m_ld[i], id_use_rs, id_rs);
                e_sb = exp_sel(m_ld[i], id_use_rt, id_rt);
                e_he = exe_m2reg && dep(exe_rn, exe_wreg);
                e_hm = (m_ld[i] == 2) && mem_m2reg && dep(mem_rn, mem_wreg);
                e_st = !rst && !flush && (m_extra[i] > 0 || e_he || e_hm);
                chk($sformatf("u%0d.fwd_a", i+1), 64'(o_fa[i]), 64'(e_sa));
                chk($sformatf("u%0d.fwd_b", i+1), 64'(o_fb[i]), 64'(e_sb));
                chk($sformatf("u%0d.id_ra", i+1), 64'(o_ra[i]), 64'(src(e_sa, id_ra_org)));
                chk($sformatf("u%0d.id_rb", i+1), 64'(o_rb[i]), 64'(src(e_sb, id_rb_org)));
                chk($sformatf("u%0d.stall", i+1), 64'(o_st[i]), 64'(e_st));
                chk($sformatf("u%0d.id_wreg_q", i+1), 64'(o_wq[i]),
                    64'(id_wreg && !e_st && !flush && !rst));
                chk($sformatf("u%0d.id_wmem_q", i+1), 64'(o_mq[i]),
                    64'(id_wmem && !e_st && !flush && !rst));
                chk($sformatf("u%0d.stall_cnt", i+1), 64'(o_sc[i]), 64'(m_sc[i]));
                chk($sformatf("u%0d.fwd_cnt", i+1), 64'(o_fc[i]), 64'(m_fc[i]));
                if (rst) begin
                    m_extra[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
                end else begin
                    if (e_st && m_sc[i] < m_max[i]) m_sc[i]++;
                    if (!e_st && !flush && (e_sa != 0 || e_sb != 0) && m_fc[i] < m_max[i]) m_fc[i]++;
                    if (flush)                        m_extra[i] = 0;
                    else if (m_extra[i] > 0)          m_extra[i]--;
                    else if (e_he)                    m_extra[i] = m_ld[i] - 1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic clr();
        flush = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_wreg = 1; id_wmem = 1;
        id_ra_org = 32'hA0A0_0001; id_rb_org = 32'hB0B0_0002;
        exe_rn = 0; mem_rn = 0; wb_rn = 0;
        exe_wreg = 0; mem_wreg = 0; wb_wreg = 0; exe_m2reg = 0; mem_m2reg = 0;
        exe_alu = 32'h11; mem_alu = 32'h22; mem_mo = 32'hABCD; wb_wdi = 32'h33;
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic exe_load(input logic [RW-1:0] r);
        exe_wreg = 1; exe_m2reg = 1; exe_rn = r;
    endtask

    task automatic mem_load(input logic [RW-1:0] r);
        mem_wreg = 1; mem_m2reg = 1; mem_rn = r;
    endtask

    initial begin
        clr();
        rst = 1;
        @(posedge clk); #1;
        started = 1'b1;
        smp();
        chk("rst.stall", 64'(o_st[0]), 0);
        chk("rst.wreg_q", 64'(o_wq[0]), 0);
        chk("rst.stall_cnt", 64'(o_sc[1]), 0);
        nxt(); rst = 0;

        // no forwarding
        exe_wreg = 1; exe_rn = 1; id_rs = 2; id_rt = 4; id_use_rs = 1; id_use_rt = 1;
        smp();
        chk("nofwd.fwd_a", 64'(o_fa[0]), 0);
        chk("nofwd.id_ra", 64'(o_ra[0]), 64'h A0A0_0001);
        chk("nofwd.wreg_q", 64'(o_wq[0]), 1);
        nxt();

        // double hit, then peel stages away
        clr(); exe_wreg = 1; exe_rn = 1; mem_wreg = 1; mem_rn = 1; id_rs = 1; id_use_rs = 1;
        smp();
        chk("dbl.fwd_a", 64'(o_fa[0]), 1);
        chk("dbl.id_ra", 64'(o_ra[0]), 64'h11);
        chk("nofwd.fwd_cnt", 64'(o_fc[1]), 0);
        nxt();
        exe_wreg = 0;
        smp();
        chk("mem.fwd_a", 64'(o_fa[0]), 2);
        chk("mem.id_ra", 64'(o_ra[0]), 64'h22);
        nxt();
        mem_wreg = 0; wb_wreg = 1; wb_rn = 1;
        smp();
        chk("wb.fwd_a", 64'(o_fa[1]), 4);
        chk("wb.id_ra", 64'(o_ra[1]), 64'h33);
        nxt();
        clr();
        smp();
        chk("dbl.fwd_cnt", 64'(o_fc[1]), 3);
        nxt();

        // load-use: load in EXE, dependent rt in ID
        clr(); exe_load(5); id_rt = 5; id_use_rt = 1;
        smp();
        chk("lu.u1.stall", 64'(o_st[0]), 1);
        chk("lu.u1.wreg_q", 64'(o_wq[0]), 0);
        chk("lu.u2.stall", 64'(o_st[1]), 1);
        nxt();
        clr(); mem_load(5); id_rt = 5; id_use_rt = 1;
        smp();
        chk("lu.u1.stall2", 64'(o_st[0]), 0);
        chk("lu.u1.fwd_b", 64'(o_fb[0]), 3);
        chk("lu.u1.id_rb", 64'(o_rb[0]), 64'hABCD);
        chk("lu.u1.stall_cnt", 64'(o_sc[0]), 1);
        chk("lu.u2.stall2", 64'(o_st[1]), 1);
        nxt();
        clr(); wb_wreg = 1; wb_rn = 5; id_rt = 5; id_use_rt = 1;
        smp();
        chk("lu.u2.stall3", 64'(o_st[1]), 0);
        chk("lu.u2.fwd_b", 64'(o_fb[1]), 4);
        chk("lu.u2.id_rb", 64'(o_rb[1]), 64'h33);
        chk("lu.u2.stall_cnt", 64'(o_sc[1]), 2);
        nxt();

        // load in MEM with dependent in ID
        clr(); mem_load(6); id_rs = 6; id_use_rs = 1;
        smp();
        chk("ml.u2.stall", 64'(o_st[1]), 1);
        chk("ml.u1.stall", 64'(o_st[0]), 0);
        chk("ml.u1.fwd_a", 64'(o_fa[0]), 3);
        nxt();
        clr(); wb_wreg = 1; wb_rn = 6; id_rs = 6; id_use_rs = 1;
        smp();
        chk("ml.u2.stall2", 64'(o_st[1]), 0);
        chk("ml.u2.fwd_a", 64'(o_fa[1]), 4);
        nxt();

        // destination-only rt and register zero
        clr(); exe_load(5); id_rt = 5; id_use_rt = 0; id_rs = 2; id_use_rs = 1;
        smp();
        chk("dest.u2.stall", 64'(o_st[1]), 0);
        chk("dest.u1.fwd_b", 64'(o_fb[0]), 0);
        nxt();
        clr(); exe_load(0); id_rs = 0; id_use_rs = 1;
        smp();
        chk("r0.u2.stall", 64'(o_st[1]), 0);
        chk("r0.u1.fwd_a", 64'(o_fa[0]), 0);
        nxt();

        // flush in the second HOLD cycle
        clr(); exe_load(7); id_rs = 7; id_use_rs = 1;
        smp(); nxt();
        clr(); mem_load(7); id_rs = 7; id_use_rs = 1; flush = 1;
        smp();
        chk("fl.u2.stall", 64'(o_st[1]), 0);
        chk("fl.u2.wreg_q", 64'(o_wq[1]), 0);
        chk("fl.u1.wmem_q", 64'(o_mq[0]), 0);
        nxt();
        clr();
        smp();
        chk("fl.u2.after", 64'(o_st[1]), 0);
        nxt();
        clr(); exe_load(7); id_rs = 7; id_use_rs = 1; flush = 1;
        smp();
        chk("flrun.u1.stall", 64'(o_st[0]), 0);
        nxt();

        // reset during HOLD
        clr(); exe_load(7); id_rs = 7; id_use_rs = 1;
        smp(); nxt();
        clr(); rst = 1;
        smp();
        chk("rh.u2.stall", 64'(o_st[1]), 0);
        nxt();
        rst = 0; clr();
        smp();
        chk("rh.u2.stall2", 64'(o_st[1]), 0);
        chk("rh.u2.stall_cnt", 64'(o_sc[1]), 0);
        chk("rh.u1.fwd_cnt", 64'(o_fc[0]), 0);
        nxt();

        // saturation of the 4-bit stall counter
        clr(); exe_load(5); id_rt = 5; id_use_rt = 1;
        repeat (20) begin smp(); nxt(); end
        clr();
        smp();
        chk("sat.u1.stall_cnt", 64'(o_sc[0]), 15);
        nxt();
        repeat (2) nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fwd_stall_ctrl.md
Name: fwd_stall_ctrl

Overview:
- Parametrised forwarding and load-use interlock controller for the 5-stage pipeline, instantiated beside the ID stage.
- Selects each ID operand from five sources: register file, EXE ALU, MEM ALU, MEM load data or WB write-back data.
- Generates the ID hold/bubble for load-use hazards, with a configurable number of bubble cycles, held by an internal FSM.
- Gates ID write enables during bubbles and flushes, and keeps saturating stall and forward performance counters.

Parameters:
DW, 32, datapath width
RW, 5, register-number width; register 0 is hard-wired zero
LD_STALL, 1, load-use bubble cycles; legal values 1 or 2 (2 = load data usable only from WB)
CNT_W, 16, performance-counter width

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  synchronous, active-high
flush  in  1  taken branch/jump squashes ID this cycle
id_rs  in  RW  ID source A register
id_rt  in  RW  ID source B register
id_use_rs  in  1  ID reads rs
id_use_rt  in  1  ID reads rt as a source (low for immediate/load-dest forms)
id_wreg  in  1  ID register-write enable, ungated
id_wmem  in  1  ID memory-write enable, ungated
id_ra_org  in  DW  register-file read A
id_rb_org  in  DW  register-file read B
exe_rn, mem_rn, wb_rn  in  RW  destination registers per stage
exe_wreg, mem_wreg, wb_wreg  in  1  write enables per stage
exe_m2reg, mem_m2reg  in  1  stage holds a load
exe_alu, mem_alu  in  DW  ALU results
mem_mo  in  DW  data-memory read data
wb_wdi  in  DW  write-back data
id_ra, id_rb  out  DW  forwarded operands
fwd_a, fwd_b  out  3  operand select codes
stall  out  1  freezes PC and IF/ID register
id_wreg_q, id_wmem_q  out  1  enables gated by ~(stall|flush)
stall_cnt  out  CNT_W  cycles with stall=1
fwd_cnt  out  CNT_W  cycles with any forward taken

Behaviour:
- Match terms, defined per operand X∈{rs,rt} and stage S:
  - hitS_X = use_X & S_wreg & (S_rn==X) & (X!=0).
  - Register 0 is never forwarded and never stalls.
- Select encoding: 000 id_*_org, 001 exe_alu, 010 mem_alu, 011 mem_mo, 100 wb_wdi.
- Select priority is EXE > MEM > WB:
  - EXE hit with ~exe_m2reg → 001.
  - MEM hit: ~mem_m2reg → 010; mem_m2reg with LD_STALL=1 → 011.
  - WB hit → 100.
  - Otherwise → 000.
- EXE-load hits and, when LD_STALL=2, MEM-load hits are never a usable forward; they always raise a hazard instead.
- id_ra/id_rb are combinational muxes of the select codes.
- Hazard conditions:
  - hazE = (hitE_rs|hitE_rt) & exe_m2reg.
  - hazM = (hitM_rs|hitM_rt) & mem_m2reg & (LD_STALL==2).
- FSM states: RUN, HOLD; 2-bit counter cnt. Reset → RUN, cnt=0.
- RUN state:
  - stall = (hazE|hazM) & ~flush, combinationally in the same cycle.
  - hazE with LD_STALL=2 → load cnt=1, go HOLD.
  - All other stalls are single-cycle and stay in RUN.
- HOLD state:
  - stall=1 unconditionally.
  - cnt decrements each cycle; return to RUN when cnt reaches 0 (HOLD lasts cnt cycles).
- Total bubbles per hazard:
  - hazE: exactly LD_STALL.
  - hazM: exactly 1.
  - After the bubbles the dependent instruction forwards from MEM (011) or WB (100).
- Flush:
  - Forces RUN, cnt=0, stall=0 in the flush cycle.
  - id_wreg_q = id_wmem_q = 0 that cycle.
  - Flush has priority over every hazard and over HOLD.
- Bubble gating: id_wreg_q = id_wreg & ~(stall|flush); same for id_wmem_q.
- Counters (synchronous, cleared by Reset, saturate at all-ones, no wrap):
  - stall_cnt += 1 on every cycle with stall=1.
  - fwd_cnt += 1 on every cycle with stall=0 & flush=0 & (fwd_a!=0 | fwd_b!=0).
- Reset asserted mid-HOLD: the next cycle is RUN, stall=0, counters 0.
- Output values during Reset: stall=0, gated enables 0; mux outputs stay combinational.

Test Plan:
- No forwarding: add r3 after add r1 (exe_rn=1), id_rs=2, id_rt=4 → fwd_a=fwd_b=000, id_ra=id_ra_org, stall=0, fwd_cnt unchanged.
- Double hit: exe_alu=0x11 to r1 and mem_alu=0x22 to r1, id_rs=1 → fwd_a=001, id_ra=0x11; with EXE removed → 010, 0x22; with MEM removed and WB to r1 with wb_wdi=0x33 → 100, 0x33.
- Load-use with LD_STALL=1: lw r5 in EXE, id_rt=5, use_rt=1 → stall=1 for exactly 1 cycle, id_wreg_q=0. Next cycle mem_mo=0xABCD gives fwd_b=011, id_rb=0xABCD. stall_cnt=1.
- Load-use with LD_STALL=2: same stimulus → stall for 2 cycles, then fwd_b=100 from wb_wdi. Separately, lw in MEM with a dependent in ID → exactly 1 bubble.
- Dest-only register: id_use_rt=0, id_rt=exe_rn=5, exe load → stall=0. id_rs=0 against a load to r0 → stall=0, fwd_a=000.
- Flush and reset mid-operation: flush in the second HOLD cycle → stall=0 that cycle and RUN after. Reset during HOLD → RUN, stall_cnt=fwd_cnt=0. Force CNT_W=4 with 20 stall cycles → stall_cnt holds 15.
